// File: rtl/mpsoc_mpram_arbiter.sv
// Round-robin arbiter sharing one SRAM request port between PORTS requesters,
// with capped locked bursts and a one-cycle tagged read-data return.
module mpsoc_mpram_arbiter #(
    parameter int PORTS          = 2,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int MAX_BURST      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [PORTS-1:0]                    m_req_i,
    input  logic [PORTS-1:0]                    m_lock_i,
    input  logic [PORTS-1:0]                    m_we_i,
    input  logic [PORTS*AXI_ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [PORTS*AXI_DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [PORTS*AXI_DATA_WIDTH-1:0]     m_data_i,
    output logic [PORTS-1:0]                    m_gnt_o,
    output logic [PORTS-1:0]                    m_rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]           m_rdata_o,
    output logic                                req_o,
    output logic                                we_o,
    output logic [AXI_ADDR_WIDTH-1:0]           addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0]         be_o,
    output logic [AXI_DATA_WIDTH-1:0]           data_o,
    input  logic [AXI_DATA_WIDTH-1:0]           data_i
);

    localparam int IW  = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int BEW = AXI_DATA_WIDTH / 8;
    localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);
    localparam logic [IW-1:0] LAST_PORT = IW'(PORTS - 1);

    logic [IW-1:0]    last_q, last_d;
    logic             locked_q, locked_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [PORTS-1:0] rd_q, rd_d;

    logic [AXI_ADDR_WIDTH-1:0] addr_arr [PORTS];
    logic [AXI_DATA_WIDTH-1:0] data_arr [PORTS];
    logic [BEW-1:0]            be_arr   [PORTS];

    logic          lock_hit;
    logic          grant_valid;
    logic          rr_found;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] win_idx;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_unpack
        assign addr_arr[gi] = m_addr_i[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign data_arr[gi] = m_data_i[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign be_arr[gi]   = m_be_i[gi*BEW +: BEW];
    end

    // Lock owner keeps the port while requesting and under the cap;
    // otherwise scan starting one past the last granted port.
    always_comb begin
        lock_hit = locked_q && m_req_i[owner_q] && (beat_q < BURST_CAP);
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int i = 1; i <= PORTS; i++) begin
            scan_idx = IW'((int'(last_q) + i) % PORTS);
            if (!rr_found && m_req_i[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
        win_idx     = lock_hit ? owner_q : rr_idx;
        grant_valid = (|m_req_i) && !rst_i;
    end

    always_comb begin
        m_gnt_o = '0;
        req_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = '0;
        be_o    = '0;
        data_o  = '0;
        if (grant_valid) begin
            m_gnt_o[win_idx] = 1'b1;
            req_o            = 1'b1;
            we_o             = m_we_i[win_idx];
            addr_o           = addr_arr[win_idx];
            be_o             = be_arr[win_idx];
            data_o           = data_arr[win_idx];
        end
    end

    always_comb begin
        last_d   = last_q;
        locked_d = locked_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        rd_d     = '0;
        if (grant_valid) begin
            last_d           = win_idx;
            owner_d          = win_idx;
            rd_d[win_idx]    = !m_we_i[win_idx];
            if ((win_idx != owner_q) || !locked_q) begin
                beat_d = BW'(1);
            end else begin
                beat_d = beat_q + BW'(1);
            end
            // The beat that reaches the cap releases the lock regardless of m_lock_i.
            locked_d = m_lock_i[win_idx] && (beat_d < BURST_CAP);
        end else begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q   <= LAST_PORT;
            locked_q <= 1'b0;
            owner_q  <= '0;
            beat_q   <= '0;
            rd_q     <= '0;
        end else begin
            last_q   <= last_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            rd_q     <= rd_d;
        end
    end

    assign m_rvalid_o = rd_q;
    assign m_rdata_o  = data_i;

endmodule

// File: tb/tb_mpsoc_mpram_arbiter.sv
// Bench for mpsoc_mpram_arbiter: directed vector table, a forced-release sequence,
// and randomized traffic checked against an integer-level arbitration model.
module tb_mpsoc_mpram_arbiter;

    localparam int P   = 2;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int MB  = 4;
    localparam int BEW = DW / 8;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic [P-1:0]       m_req_i = '0;
    logic [P-1:0]       m_lock_i = '0;
    logic [P-1:0]       m_we_i = '0;
    logic [P*AW-1:0]    m_addr_i = '0;
    logic [P*BEW-1:0]   m_be_i = '0;
    logic [P*DW-1:0]    m_data_i = '0;
    logic [P-1:0]       m_gnt_o;
    logic [P-1:0]       m_rvalid_o;
    logic [DW-1:0]      m_rdata_o;
    logic               req_o;
    logic               we_o;
    logic [AW-1:0]      addr_o;
    logic [BEW-1:0]     be_o;
    logic [DW-1:0]      data_o;
    logic [DW-1:0]      data_i = '0;

    mpsoc_mpram_arbiter #(
        .PORTS(P), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .m_req_i(m_req_i), .m_lock_i(m_lock_i),
        .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_be_i(m_be_i), .m_data_i(m_data_i),
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o),
        .data_o(data_o), .data_i(data_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: plain integers describing arbitration history.
    int            m_last = P - 1;
    int            m_owner = 0;
    int            m_beat = 0;
    int            m_rd = -1;
    bit            m_locked = 1'b0;
    bit            known = 1'b0;
    logic [AW-1:0] m_raddr = '0;
    logic [AW-1:0] prev_addr = '0;
    int            cyc = 0;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] lock;
        logic [1:0] we;
        logic [1:0] gnt;
        logic [1:0] rv;
        logic       chk_rv;
    } vec_t;

    vec_t vecs[26];

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_cycle(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                            input logic [1:0] w, input logic [P*AW-1:0] ad,
                            input logic [P*DW-1:0] dt, input logic [P*BEW-1:0] bb);
        int win;
        logic [P-1:0] eg;
        logic [P-1:0] erv;
        @(negedge clk);
        rst_i    = r;
        m_req_i  = rq;
        m_lock_i = lk;
        m_we_i   = w;
        m_addr_i = ad;
        m_data_i = dt;
        m_be_i   = bb;
        data_i   = ram_word(prev_addr);
        #1;
        win = -1;
        if (!r) begin
            if (m_locked && rq[m_owner] && m_beat < MB) begin
                win = m_owner;
            end else begin
                for (int off = 1; off <= P; off++) begin
                    int p;
                    p = (m_last + off) % P;
                    if (rq[p]) begin
                        win = p;
                        break;
                    end
                end
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        check("gnt", 64'(m_gnt_o), 64'(eg));
        check("req_o", 64'(req_o), 64'(win >= 0));
        if (win >= 0) begin
            check("addr_o", 64'(addr_o), 64'(ad[win*AW +: AW]));
            check("we_o", 64'(we_o), 64'(w[win]));
            check("be_o", 64'(be_o), 64'(bb[win*BEW +: BEW]));
            check("data_o", 64'(data_o), 64'(dt[win*DW +: DW]));
        end else begin
            check("idle_addr_o", 64'(addr_o), 64'(0));
        end
        if (known) begin
            erv = '0;
            if (m_rd >= 0) erv[m_rd] = 1'b1;
            check("rvalid", 64'(m_rvalid_o), 64'(erv));
            if (m_rd >= 0) check("rdata", 64'(m_rdata_o), 64'(ram_word(m_raddr)));
        end
        $display("[TB] cyc %0d rst=%0b req=%b lock=%b we=%b gnt=%b addr=%h rvalid=%b rdata=%h",
                 cyc, r, rq, lk, w, m_gnt_o, addr_o, m_rvalid_o, m_rdata_o);
        prev_addr = addr_o;
        if (r) begin
            m_last = P - 1; m_locked = 1'b0; m_owner = 0; m_beat = 0; m_rd = -1; known = 1'b1;
        end else if (win >= 0) begin
            m_beat   = (m_locked && win == m_owner) ? m_beat + 1 : 1;
            m_locked = lk[win] && (m_beat < MB);
            m_owner  = win;
            m_last   = win;
            m_rd     = w[win] ? -1 : win;
            m_raddr  = ad[win*AW +: AW];
        end else begin
            m_locked = 1'b0;
            m_rd     = -1;
        end
        cyc++;
    endtask

    localparam logic [P*AW-1:0]  AD = {32'h0000_0020, 32'h0000_0010};
    localparam logic [P*DW-1:0]  DT = {16'hBEEF, 16'h1111};
    localparam logic [P*BEW-1:0] BB = 4'b1111;

    initial begin
        //            rst   req    lock   we     gnt    rv     chk_rv
        vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
        vecs[2]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1};
        vecs[3]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 1'b1};
        vecs[4]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 1'b1};
        vecs[5]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 1'b1};
        // burst cap: port0 locked for MB beats, then port1
        vecs[6]  = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1};
        vecs[7]  = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1};
        vecs[8]  = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1};
        vecs[9]  = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1};
        vecs[10] = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 1'b1};
        // abandoned lock: port0 drops req after 2 beats; port1 then gets a full burst
        vecs[11] = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1};
        vecs[12] = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1};
        vecs[13] = '{1'b0, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 1'b1};
        vecs[14] = '{1'b0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1};
        vecs[15] = '{1'b0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1};
        vecs[16] = '{1'b0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1};
        vecs[17] = '{1'b0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 1'b1};
        // write then read
        vecs[18] = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 1'b1};
        vecs[19] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1};
        vecs[20] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};
        vecs[21] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
        // reset in the middle of a port1 locked read burst
        vecs[22] = '{1'b0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1};
        vecs[23] = '{1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1};
        vecs[24] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1};
        vecs[25] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};

        for (int i = 0; i < 26; i++) begin
            do_cycle(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].we, AD, DT, BB);
            check($sformatf("vec%0d_gnt", i), 64'(m_gnt_o), 64'(vecs[i].gnt));
            if (vecs[i].chk_rv) check($sformatf("vec%0d_rvalid", i), 64'(m_rvalid_o), 64'(vecs[i].rv));
        end

        // Sole locked requester past the cap keeps being granted (burst restarts).
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 2'b10, 2'b10, 2'b00, AD, DT, BB);
            check($sformatf("solo_lock%0d_gnt", i), 64'(m_gnt_o), 64'(2'b10));
        end
        do_cycle(1'b0, 2'b00, 2'b00, 2'b00, AD, DT, BB);
        check("solo_lock_idle_req", 64'(req_o), 64'(0));

        for (int i = 0; i < 400; i++) begin
            logic          r;
            logic [1:0]    rq, lk, w;
            logic [P*AW-1:0]  ad;
            logic [P*DW-1:0]  dt;
            logic [P*BEW-1:0] bb;
            r  = ($urandom_range(0, 39) == 0);
            rq = 2'($urandom);
            lk = 2'($urandom) | 2'($urandom);
            w  = 2'($urandom) & 2'($urandom);
            ad = {$urandom(), $urandom()};
            dt = $urandom();
            bb = 4'($urandom);
            do_cycle(r, rq, lk, w, ad, dt, bb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
